// File: rtl/loop_sequencer_pkg.sv
// Shared types and constants for the velocity loop sequencer: FSM state
// encodings, motor pin layout and default timing constants.
package loop_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_LATCH     = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_PID  = 3'd4,
    ST_APPLY     = 3'd5,
    ST_DEADTIME  = 3'd6
  } seq_state_t;

  typedef enum logic {
    DIR_CW  = 1'b0,
    DIR_CCW = 1'b1
  } dir_t;

  localparam logic [1:0] PIN_STOP    = 2'b00;
  localparam int         PIN_CW_BIT  = 1;
  localparam int         PIN_CCW_BIT = 0;

  localparam int DEF_PERIOD_CYCLES   = 50000;
  localparam int DEF_DEADTIME_CYCLES = 64;
  localparam int DEF_PID_TIMEOUT     = 1024;
  localparam int DEF_MAX_STEP        = 2048;

  // |un| of a two's complement value; -32768 maps to 32768, which still fits.
  function automatic logic [15:0] abs_clamp(input logic [15:0] un, input logic [15:0] lim);
    logic [15:0] m;
    m = un[15] ? 16'(~un + 16'd1) : un;
    return (m > lim) ? lim : m;
  endfunction

  function automatic logic [15:0] step_limit(input logic [15:0] prev, input logic [15:0] target,
                                             input logic [16:0] step);
    logic [17:0] up;
    up = {2'b00, prev} + {1'b0, step};
    if ({2'b00, target} > up) return 16'(up);
    if (({2'b00, target} + {1'b0, step}) < {2'b00, prev}) return 16'({2'b00, prev} - {1'b0, step});
    return target;
  endfunction

endpackage

// File: rtl/loop_sequencer_if.sv
// Bundle of the sequencer's data and handshake signals; master = sequencer side.
interface loop_sequencer_if;
  // PID handshake: o_pid_start is a one-cycle request carrying o_pid_sp/o_pid_pv;
  // i_pid_valid is a one-cycle response carrying i_pid_un. No backpressure either way.
  logic        i_enable;
  logic [15:0] i_setpoint;
  logic [15:0] i_velocity;
  logic [15:0] o_pid_sp;
  logic [15:0] o_pid_pv;
  logic        o_pid_start;
  logic        i_pid_valid;
  logic [15:0] i_pid_un;
  logic [15:0] o_duty;
  logic        i_pwm_out;
  logic [1:0]  o_controlPin;
  logic [2:0]  o_state;
  logic        o_timeout_err;
  logic        o_overrun;

  modport master (
    input  i_enable, i_setpoint, i_velocity, i_pid_valid, i_pid_un, i_pwm_out,
    output o_pid_sp, o_pid_pv, o_pid_start, o_duty, o_controlPin, o_state,
           o_timeout_err, o_overrun
  );

  modport slave (
    output i_enable, i_setpoint, i_velocity, i_pid_valid, i_pid_un, i_pwm_out,
    input  o_pid_sp, o_pid_pv, o_pid_start, o_duty, o_controlPin, o_state,
           o_timeout_err, o_overrun
  );
endinterface

// File: rtl/loop_tick_gen.sv
// Period counter: free-runs 0..PERIOD_CYCLES-1 while enabled, one-cycle tick at wrap.
module loop_tick_gen
  import loop_sequencer_pkg::*;
#(
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES
) (
  input  logic Clk,
  input  logic n_reset,
  input  logic enable,
  output logic tick
);

  localparam int                CNT_W = $clog2(PERIOD_CYCLES);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(PERIOD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk or negedge n_reset) begin
    if (!n_reset)          cnt <= '0;
    else if (!enable)      cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/loop_sequencer.sv
// One closed-loop velocity control period: tick -> snapshot -> PID -> duty/direction.
// Optional soft-start ramp is enabled by defining LOOP_SEQ_SOFTSTART_EN.
module loop_sequencer
  import loop_sequencer_pkg::*;
#(
  parameter int          PERIOD_CYCLES   = DEF_PERIOD_CYCLES,
  parameter int          PID_TIMEOUT     = DEF_PID_TIMEOUT,
  parameter int          DEADTIME_CYCLES = DEF_DEADTIME_CYCLES,
  parameter int          STOP_BAND       = 3,
  parameter int          STOP_VEL        = 10,
  parameter logic [15:0] DUTY_MAX        = 16'd65535
`ifdef LOOP_SEQ_SOFTSTART_EN
  , parameter int        MAX_STEP        = DEF_MAX_STEP
`endif
) (
  input  logic             Clk,
  input  logic             n_reset,
  loop_sequencer_if.master bus
);

  localparam int             TO_W    = $clog2(PID_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(PID_TIMEOUT - 1);
  localparam int             DT_W    = $clog2(DEADTIME_CYCLES + 1);
  localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEADTIME_CYCLES - 1);

  seq_state_t      state;
  dir_t            last_dir;
  logic            tick;
  logic            run;
  logic            rev_pending;
  logic            pid_start;
  logic            timeout_err;
  logic            overrun;
  logic [15:0]     pid_sp;
  logic [15:0]     pid_pv;
  logic [16:0]     err;
  logic [15:0]     duty;
  logic [15:0]     pend_mag;
  logic [TO_W-1:0] to_cnt;
  logic [DT_W-1:0] dt_cnt;

  logic [16:0]     err_abs;
  logic            stop_zone;
  dir_t            un_dir;
  logic [15:0]     un_mag;
  logic [15:0]     duty_same;
  logic [15:0]     duty_resume;
  logic [1:0]      pins;

  loop_tick_gen #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_tick (
    .Clk     (Clk),
    .n_reset (n_reset),
    .enable  (bus.i_enable),
    .tick    (tick)
  );

  assign err_abs   = err[16] ? (~err + 17'd1) : err;
  assign stop_zone = (err_abs < 17'(STOP_BAND)) && (pid_pv < 16'(STOP_VEL));
  assign un_dir    = bus.i_pid_un[15] ? DIR_CCW : DIR_CW;
  assign un_mag    = abs_clamp(bus.i_pid_un, DUTY_MAX);

`ifdef LOOP_SEQ_SOFTSTART_EN
  assign duty_same   = step_limit(duty, un_mag, 17'(MAX_STEP));
  assign duty_resume = step_limit(16'd0, pend_mag, 17'(MAX_STEP));
`else
  assign duty_same   = un_mag;
  assign duty_resume = pend_mag;
`endif

  // The PID result is folded into duty on the i_pid_valid edge so same-direction
  // updates land one cycle later; APPLY only decides whether a reversal follows.
  always_ff @(posedge Clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= ST_IDLE;
      last_dir    <= DIR_CW;
      run         <= 1'b0;
      rev_pending <= 1'b0;
      pid_start   <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
      pid_sp      <= '0;
      pid_pv      <= '0;
      err         <= '0;
      duty        <= '0;
      pend_mag    <= '0;
      to_cnt      <= '0;
      dt_cnt      <= '0;
    end else begin
      pid_start <= 1'b0;
      if (tick && (state != ST_WAIT_TICK)) overrun <= 1'b1;

      if (!bus.i_enable) begin
        state       <= ST_IDLE;
        duty        <= '0;
        run         <= 1'b0;
        rev_pending <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            duty        <= '0;
            run         <= 1'b0;
            rev_pending <= 1'b0;
            state       <= ST_WAIT_TICK;
          end
          ST_WAIT_TICK: begin
            if (tick) state <= ST_LATCH;
          end
          ST_LATCH: begin
            pid_sp    <= bus.i_setpoint;
            pid_pv    <= bus.i_velocity;
            err       <= {1'b0, bus.i_setpoint} - {1'b0, bus.i_velocity};
            pid_start <= 1'b1;
            state     <= ST_START;
          end
          ST_START: begin
            to_cnt <= '0;
            state  <= ST_WAIT_PID;
          end
          ST_WAIT_PID: begin
            if (bus.i_pid_valid) begin
              if (stop_zone) begin
                duty        <= '0;
                run         <= 1'b0;
                rev_pending <= 1'b0;
              end else if (un_dir == last_dir) begin
                duty        <= duty_same;
                run         <= 1'b1;
                rev_pending <= 1'b0;
              end else begin
                pend_mag    <= un_mag;
                rev_pending <= 1'b1;
              end
              state <= ST_APPLY;
            end else if (to_cnt == TO_LAST) begin
              timeout_err <= 1'b1;
              duty        <= '0;
              run         <= 1'b0;
              state       <= ST_WAIT_TICK;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          ST_APPLY: begin
            if (rev_pending) begin
              duty   <= '0;
              run    <= 1'b0;
              dt_cnt <= '0;
              state  <= ST_DEADTIME;
            end else begin
              state <= ST_WAIT_TICK;
            end
          end
          ST_DEADTIME: begin
            if (dt_cnt == DT_LAST) begin
              last_dir    <= (last_dir == DIR_CW) ? DIR_CCW : DIR_CW;
              duty        <= duty_resume;
              run         <= 1'b1;
              rev_pending <= 1'b0;
              state       <= ST_WAIT_TICK;
            end else begin
              dt_cnt <= dt_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Only one pin can ever carry PWM; direction and run change on the same edge.
  always_comb begin
    pins = PIN_STOP;
    if (run) begin
      if (last_dir == DIR_CW) pins[PIN_CW_BIT]  = bus.i_pwm_out;
      else                    pins[PIN_CCW_BIT] = bus.i_pwm_out;
    end
  end

  assign bus.o_pid_sp      = pid_sp;
  assign bus.o_pid_pv      = pid_pv;
  assign bus.o_pid_start   = pid_start;
  assign bus.o_duty        = duty;
  assign bus.o_controlPin  = pins;
  assign bus.o_state       = state;
  assign bus.o_timeout_err = timeout_err;
  assign bus.o_overrun     = overrun;

endmodule
